// File: rtl/logic_sweep_pkg.sv
// logic_sweep_pkg
//   Shared types and constants for the logic sweep sequencer.
//   Contents: FSM state enum, field widths (TT_W, IDX_W, CNT_W),
//   default expected truth table (0x41A2 NOR/NOT netlist).
package logic_sweep_pkg;
   localparam int TT_W  = 16;
   localparam int IDX_W = 4;
   localparam int CNT_W = 8;

   localparam logic [TT_W-1:0]  EXPECTED_DEFAULT = 16'h41A2;
   localparam logic [IDX_W-1:0] LAST_IDX         = 4'hF;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_t;
endpackage

// File: rtl/logic_sweep_ctrl_settle_timer.sv
// settle_timer
//   Down-counter timing the settle window for one input vector.
//   load   : (re)arm with SETTLE_CYCLES-1; has priority over en
//   en     : count down while the controller is in SETTLE
//   expired: high on the last SETTLE cycle, so SETTLE lasts exactly
//            SETTLE_CYCLES cycles after a load
// Ports: clk, rst_n (async, active low), load, en, expired.
module settle_timer
   import logic_sweep_pkg::*;
#(
   parameter int SETTLE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic en,
   output logic expired
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (load)
         cnt <= CNT_W'(SETTLE_CYCLES - 1);
      else if (en && (cnt != '0))
         cnt <= cnt - CNT_W'(1);
   end

   assign expired = (cnt == '0);

endmodule

// File: rtl/logic_sweep_ctrl.sv
// logic_sweep_ctrl
//   Sweeps all 16 input vectors of a 4-in/1-out logic circuit, holds each
//   vector for SETTLE_CYCLES+1 cycles, samples the output on the last cycle
//   and compares the captured truth table against EXPECTED_TT.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start, abort        master handshake (start ignored while busy,
//                       abort ignored in IDLE and DONE)
//   dut_in[3:0]         vector to circuit ({in1,in2,in3,in4} = index)
//   dut_out             circuit output
//   busy, done          sweep in progress / one-cycle completion pulse
//   pass                captured == EXPECTED_TT, valid from done to next start
//   captured[15:0]      sampled truth table
//   mismatch_cnt[4:0]   mismatching vectors (5 bits so 16 cannot wrap)
//   fail_valid, fail_idx first mismatch record
// Build option: STOP_ON_FIRST_FAIL_EN ends the sweep at the first mismatch.
module logic_sweep_ctrl
   import logic_sweep_pkg::*;
#(
   parameter int              SETTLE_CYCLES = 4,
   parameter logic [TT_W-1:0] EXPECTED_TT   = EXPECTED_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   output logic [IDX_W-1:0] dut_in,
   input  logic             dut_out,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [TT_W-1:0]  captured,
   output logic [4:0]       mismatch_cnt,
   output logic             fail_valid,
   output logic [IDX_W-1:0] fail_idx
);

   state_t           state, state_nx;
   logic [IDX_W-1:0] idx;
   logic             accept, do_sample, tmr_load, tmr_expired;
   logic             miss, stop_now;
   logic [4:0]       mismatch_nx;

   settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (tmr_load),
      .en      (state == SETTLE),
      .expired (tmr_expired)
   );

   assign miss        = (dut_out != EXPECTED_TT[idx]);
   assign mismatch_nx = mismatch_cnt + {4'd0, miss};

`ifdef STOP_ON_FIRST_FAIL_EN
   assign stop_now = miss;
`else
   assign stop_now = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      accept    = 1'b0;
      do_sample = 1'b0;
      tmr_load  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept   = 1'b1;
               tmr_load = 1'b1;
               state_nx = SETTLE;
            end
         end
         SETTLE: begin
            if (abort)            state_nx = IDLE;
            else if (tmr_expired) state_nx = SAMPLE;
         end
         SAMPLE: begin
            // abort wins over the sample so the partial results stay frozen
            if (abort) begin
               state_nx = IDLE;
            end else begin
               do_sample = 1'b1;
               if ((idx == LAST_IDX) || stop_now) begin
                  state_nx = DONE;
               end else begin
                  state_nx = SETTLE;
                  tmr_load = 1'b1;
               end
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // busy/done registered from next state so they line up with the FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         busy <= (state_nx != IDLE);
         done <= (state_nx == DONE);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx          <= '0;
         captured     <= '0;
         mismatch_cnt <= '0;
         fail_valid   <= 1'b0;
         fail_idx     <= '0;
         pass         <= 1'b0;
      end else if (accept) begin
         idx          <= '0;
         captured     <= '0;
         mismatch_cnt <= '0;
         fail_valid   <= 1'b0;
         fail_idx     <= '0;
         pass         <= 1'b0;
      end else if (do_sample) begin
         captured[idx] <= dut_out;
         if (miss) begin
            mismatch_cnt <= mismatch_nx;
            if (!fail_valid) begin
               fail_valid <= 1'b1;
               fail_idx   <= idx;
            end
         end
         if (state_nx == DONE) pass <= (mismatch_nx == 5'd0);
         else                  idx  <= idx + IDX_W'(1);
      end else if (abort && (state == SETTLE || state == SAMPLE)) begin
         pass <= 1'b0;
      end
   end

   assign dut_in = idx;

endmodule

// File: tb/tb_logic_sweep_ctrl.sv
module tb_logic_sweep_ctrl;

   localparam int             S   = 4;
   localparam logic [15:0]    GOLD = 16'h41A2;

   typedef struct {
      logic [15:0] cap;
      logic [4:0]  cnt;
      logic        fv;
      logic [3:0]  fi;
      logic        pass;
      int          cycles;
   } exp_t;

   logic        clk, rst_n, start, abort, dut_out;
   logic [3:0]  dut_in;
   logic        busy, done, pass, fail_valid;
   logic [15:0] captured;
   logic [4:0]  mismatch_cnt;
   logic [3:0]  fail_idx;

   int   mode;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   logic_sweep_ctrl #(.SETTLE_CYCLES(S), .EXPECTED_TT(GOLD)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .dut_in(dut_in), .dut_out(dut_out), .busy(busy), .done(done),
      .pass(pass), .captured(captured), .mismatch_cnt(mismatch_cnt),
      .fail_valid(fail_valid), .fail_idx(fail_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // circuit models: 0 golden, 1 stuck-at-0, 2 golden with vector 8 inverted
   function automatic logic resp(input int m, input logic [3:0] v);
      logic [15:0] t;
      t = GOLD;
      case (m)
         1:       return 1'b0;
         2:       return t[v] ^ (v == 4'd8);
         default: return t[v];
      endcase
   endfunction

   always_comb dut_out = resp(mode, dut_in);

   function automatic exp_t model(input int m);
      exp_t e;
      logic [15:0] g;
      logic o;
      g = GOLD;
      e.cap = '0; e.cnt = '0; e.fv = 1'b0; e.fi = '0; e.cycles = 16 * (S + 1);
      for (int i = 0; i < 16; i++) begin
         o = resp(m, 4'(i));
         e.cap[i] = o;
         if (o != g[i]) begin
            e.cnt = e.cnt + 5'd1;
            if (!e.fv) begin
               e.fv = 1'b1;
               e.fi = 4'(i);
            end
`ifdef STOP_ON_FIRST_FAIL_EN
            e.cycles = (i + 1) * (S + 1);
            break;
`endif
         end
      end
      e.pass = (e.cnt == 5'd0);
      return e;
   endfunction

   task automatic test_reset();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || captured !== 16'h0 ||
          mismatch_cnt !== 5'd0 || fail_valid !== 1'b0 || fail_idx !== 4'd0 || dut_in !== 4'd0) begin
         errors++;
         $display("FAIL reset_values: busy=%b done=%b pass=%b cap=%h cnt=%0d fv=%b fi=%0d in=%0d, want all zero",
                  busy, done, pass, captured, mismatch_cnt, fail_valid, fail_idx, dut_in);
      end
   endtask

   task automatic run_sweep(input string name, input int m, input bit spam);
      exp_t e, g;
      int   n;
      bit   seen;
      mode = m;
      e = model(m);
      sb.push_back(e);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      checks++;
      if (busy !== 1'b1 || dut_in !== 4'd0) begin
         errors++;
         $display("FAIL %s start_ack: busy=%b dut_in=%0d, want busy=1 dut_in=0", name, busy, dut_in);
      end
      n = 0; seen = 0;
      while (!seen && n < 300) begin
         start = (spam && n < 60 && (n % 7) == 3);
         @(negedge clk); n++;
         if (done === 1'b1) seen = 1;
      end
      start = 1'b0;
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s done_timeout: no done after %0d cycles", name, n);
         void'(sb.pop_front());
      end else begin
         g = sb.pop_front();
         checks++;
         if (n != g.cycles) begin
            errors++;
            $display("FAIL %s done_latency: got %0d want %0d", name, n, g.cycles);
         end
         checks++;
         if (captured !== g.cap || mismatch_cnt !== g.cnt || fail_valid !== g.fv ||
             fail_idx !== g.fi || pass !== g.pass || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s results: cap=%h cnt=%0d fv=%b fi=%0d pass=%b busy=%b, want cap=%h cnt=%0d fv=%b fi=%0d pass=%b busy=1",
                     name, captured, mismatch_cnt, fail_valid, fail_idx, pass, busy,
                     g.cap, g.cnt, g.fv, g.fi, g.pass);
         end
         @(negedge clk);
         checks++;
         if (done !== 1'b0 || busy !== 1'b0 || pass !== g.pass || captured !== g.cap) begin
            errors++;
            $display("FAIL %s after_done: done=%b busy=%b pass=%b cap=%h, want 0 0 %b %h",
                     name, done, busy, pass, captured, g.pass, g.cap);
         end
         if (spam) begin
            n = 0;
            for (int i = 0; i < 30; i++) begin
               @(negedge clk);
               if (done === 1'b1 || busy === 1'b1) n++;
            end
            checks++;
            if (n != 0) begin
               errors++;
               $display("FAIL %s single_sweep: %0d busy/done cycles after completion, want 0", name, n);
            end
         end
      end
   endtask

   task automatic wait_vec(input logic [3:0] v, output bit ok);
      ok = 0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (dut_in === v) ok = 1;
      end
   endtask

   task automatic test_abort();
      bit ok;
      int n;
      mode = 0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      wait_vec(4'd5, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL abort_reach_vec5: dut_in stuck at %0d", dut_in);
      end
      abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || captured !== 16'h0002 ||
          mismatch_cnt !== 5'd0 || fail_valid !== 1'b0 || dut_in !== 4'd5) begin
         errors++;
         $display("FAIL abort_state: busy=%b done=%b pass=%b cap=%h cnt=%0d fv=%b in=%0d, want 0 0 0 0002 0 0 5",
                  busy, done, pass, captured, mismatch_cnt, fail_valid, dut_in);
      end
      n = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) n++;
      end
      checks++;
      if (n != 0) begin
         errors++;
         $display("FAIL abort_no_done: %0d busy/done cycles after abort, want 0", n);
      end
      run_sweep("abort_resweep", 0, 0);
   endtask

   task automatic test_midreset();
      bit ok;
      mode = 0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      wait_vec(4'd10, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL rst_reach_vec10: dut_in stuck at %0d", dut_in);
      end
      #2 rst_n = 1'b0;
      #1 test_reset();
      @(negedge clk); rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || dut_in !== 4'd0 || done !== 1'b0) begin
         errors++;
         $display("FAIL rst_release_idle: busy=%b in=%0d done=%b, want 0 0 0", busy, dut_in, done);
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 0;
      repeat (3) @(negedge clk);
      test_reset();
      rst_n = 1'b1;
      // abort while idle must be ignored
      abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL idle_abort: busy=%b done=%b, want 0 0", busy, done);
      end
      run_sweep("golden", 0, 0);
      run_sweep("stuck0", 1, 0);
      run_sweep("flip8", 2, 0);
      run_sweep("back_to_back", 0, 0);
      run_sweep("start_spam", 0, 1);
      test_abort();
      test_midreset();
      run_sweep("post_reset", 2, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
